// File: rtl/tdm_demux_1x4_if.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x4_if
// Bundles the TDM input stream and the four demultiplexed output channels.
//   din/din_valid/frame_sync/ch_en : serial beat, slot-0 marker, channel mask
//   y0..y3/y_valid                 : per-channel registered data and strobes
//   slot/locked                    : alignment status
//   frame_done/sync_err/frame_cnt  : frame accounting
// master modport: stream source / status observer.
// slave  modport: the demultiplexer.
// ---------------------------------------------------------------------------
interface tdm_demux_1x4_if #(
    parameter int W = 8
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [3:0]   ch_en;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    logic [3:0]   y_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         frame_done;
    logic         sync_err;
    logic [7:0]   frame_cnt;

    modport master (
        output din, din_valid, frame_sync, ch_en,
        input  y0, y1, y2, y3, y_valid, slot, locked, frame_done, sync_err, frame_cnt
    );

    modport slave (
        input  din, din_valid, frame_sync, ch_en,
        output y0, y1, y2, y3, y_valid, slot, locked, frame_done, sync_err, frame_cnt
    );
endinterface

// File: rtl/tdm_demux_1x4.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x4
// Splits a 4-slot time-division-multiplexed stream into four channels.
// A beat carrying frame_sync marks slot 0; HUNT waits for it, LOCKED then
// routes each valid beat to the channel of its slot. Misplaced or missing
// sync beats raise sync_err; complete frames raise frame_done and count.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : tdm_demux_1x4_if slave modport (stream in, channels/status out)
// All outputs are registered; one cycle latency from accepted beat.
// ---------------------------------------------------------------------------
module tdm_demux_1x4 #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux_1x4_if.slave bus
);
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t       state_p0;
    logic [1:0]   slot_p0;
    logic         locked_p0;
    logic [W-1:0] y_p0 [4];
    logic [3:0]   y_valid_p0;
    logic         frame_done_p0;
    logic         sync_err_p0;
    logic [7:0]   frame_cnt_p0;

    state_t       nxt_state;
    logic [1:0]   nxt_slot;
    logic         wr_go;
    logic [1:0]   wr_ch;
    logic         fd_set;
    logic         se_set;

    // Beat decode: decides where the current beat goes and how alignment moves.
    always_comb begin
        nxt_state = state_p0;
        nxt_slot  = slot_p0;
        wr_go     = 1'b0;
        wr_ch     = 2'd0;
        fd_set    = 1'b0;
        se_set    = 1'b0;
        if (bus.din_valid) begin
            case (state_p0)
                HUNT: begin
                    if (bus.frame_sync) begin
                        wr_go     = 1'b1;
                        nxt_state = LOCKED;
                        nxt_slot  = 2'd1;
                    end
                end
                LOCKED: begin
                    if (bus.frame_sync) begin
                        // Sync always restarts the frame at slot 0; only an
                        // early one (mid-frame) is an error, and the partial
                        // frame is dropped from the accounting.
                        wr_go    = 1'b1;
                        nxt_slot = 2'd1;
                        se_set   = (slot_p0 != 2'd0);
                    end else if (slot_p0 == 2'd0) begin
                        // Missing sync: beat is dropped and alignment lost.
                        se_set    = 1'b1;
                        nxt_state = HUNT;
                        nxt_slot  = 2'd0;
                    end else begin
                        wr_go    = 1'b1;
                        wr_ch    = slot_p0;
                        nxt_slot = slot_p0 + 2'd1;
                        fd_set   = (slot_p0 == 2'd3);
                    end
                end
                default: begin
                    nxt_state = HUNT;
                    nxt_slot  = 2'd0;
                end
            endcase
        end
    end

    // Output/state register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0      <= HUNT;
            slot_p0       <= 2'd0;
            locked_p0     <= 1'b0;
            y_p0[0]       <= '0;
            y_p0[1]       <= '0;
            y_p0[2]       <= '0;
            y_p0[3]       <= '0;
            y_valid_p0    <= 4'd0;
            frame_done_p0 <= 1'b0;
            sync_err_p0   <= 1'b0;
            frame_cnt_p0  <= 8'd0;
        end else begin
            state_p0      <= nxt_state;
            slot_p0       <= nxt_slot;
            locked_p0     <= (nxt_state == LOCKED);
            y_valid_p0    <= 4'd0;
            frame_done_p0 <= fd_set;
            sync_err_p0   <= se_set;
            // Masked channels still consume their slot but keep old data.
            if (wr_go && bus.ch_en[wr_ch]) begin
                y_p0[wr_ch]       <= bus.din;
                y_valid_p0[wr_ch] <= 1'b1;
            end
            if (fd_set) begin
                frame_cnt_p0 <= frame_cnt_p0 + 8'd1;
            end
        end
    end

    assign bus.y0         = y_p0[0];
    assign bus.y1         = y_p0[1];
    assign bus.y2         = y_p0[2];
    assign bus.y3         = y_p0[3];
    assign bus.y_valid    = y_valid_p0;
    assign bus.slot       = slot_p0;
    assign bus.locked     = locked_p0;
    assign bus.frame_done = frame_done_p0;
    assign bus.sync_err   = sync_err_p0;
    assign bus.frame_cnt  = frame_cnt_p0;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1x4
// Directed and randomized stimulus for tdm_demux_1x4, compared against a
// frame-position reference model after every clock edge and during reset.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1x4;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    tdm_demux_1x4_if #(.W(W)) bus ();

    tdm_demux_1x4 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: is the stream aligned, and which frame position is due.
    bit         m_locked;
    int         m_pos;
    logic [7:0] m_y [4];
    logic [3:0] m_yv;
    bit         m_fd;
    bit         m_se;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_pos    = 0;
        for (int i = 0; i < 4; i++) m_y[i] = 8'h00;
        m_yv = 4'h0;
        m_fd = 0;
        m_se = 0;
        m_cnt = 0;
    endtask

    task automatic model_write(input int ch, input logic [7:0] d, input logic [3:0] en);
        if (en[ch]) begin
            m_y[ch]  = d;
            m_yv[ch] = 1'b1;
        end
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [7:0] d, input logic [3:0] en);
        m_yv = 4'h0;
        m_fd = 0;
        m_se = 0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                model_write(0, d, en);
                m_locked = 1;
                m_pos = 1;
            end
        end else if (s) begin
            if (m_pos != 0) m_se = 1;
            model_write(0, d, en);
            m_pos = 1;
        end else if (m_pos == 0) begin
            m_se = 1;
            m_locked = 0;
        end else begin
            model_write(m_pos, d, en);
            if (m_pos == 3) begin
                m_fd = 1;
                m_cnt = (m_cnt + 1) % 256;
            end
            m_pos = (m_pos + 1) % 4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y0"}, 32'(bus.y0), 32'(m_y[0]));
        chk({tag, ".y1"}, 32'(bus.y1), 32'(m_y[1]));
        chk({tag, ".y2"}, 32'(bus.y2), 32'(m_y[2]));
        chk({tag, ".y3"}, 32'(bus.y3), 32'(m_y[3]));
        chk({tag, ".y_valid"}, 32'(bus.y_valid), 32'(m_yv));
        chk({tag, ".slot"}, 32'(bus.slot), 32'(m_pos));
        chk({tag, ".locked"}, 32'(bus.locked), 32'(m_locked));
        chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(m_fd));
        chk({tag, ".sync_err"}, 32'(bus.sync_err), 32'(m_se));
        chk({tag, ".frame_cnt"}, 32'(bus.frame_cnt), 32'(m_cnt));
    endtask

    // Called just after an edge; drives a beat, clocks it, checks outputs.
    task automatic step(input string tag, input bit v, input bit s,
                        input logic [7:0] d, input logic [3:0] en);
        bus.din_valid  = v;
        bus.frame_sync = s;
        bus.din        = d;
        bus.ch_en      = en;
        @(posedge clk);
        model_beat(v, s, d, en);
        #1;
        check_all(tag);
    endtask

    task automatic frame(input string tag, input logic [7:0] base, input logic [3:0] en);
        for (int i = 0; i < 4; i++) step(tag, 1'b1, (i == 0), base + 8'(i), en);
    endtask

    initial begin
        int c0;
        rst_n          = 1'b0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        bus.ch_en      = 4'hF;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        #2 rst_n = 1'b1;
        @(posedge clk);
        model_beat(0, 0, 0, 4'hF);
        #1;
        check_all("idle_after_reset");

        // Unsynchronised beats are discarded while hunting.
        step("hunt_aa", 1, 0, 8'hAA, 4'hF);
        step("hunt_bb", 1, 0, 8'hBB, 4'hF);

        // Lock and one full frame.
        step("lock_11", 1, 1, 8'h11, 4'hF);
        step("lock_22", 1, 0, 8'h22, 4'hF);
        step("lock_33", 1, 0, 8'h33, 4'hF);
        step("lock_44", 1, 0, 8'h44, 4'hF);
        chk("lock_cnt_is_1", 32'(bus.frame_cnt), 32'd1);
        step("lock_idle", 0, 0, 8'h00, 4'hF);

        // Early sync mid-frame.
        step("early_01", 1, 1, 8'h01, 4'hF);
        step("early_02", 1, 0, 8'h02, 4'hF);
        step("early_03", 1, 1, 8'h03, 4'hF);
        chk("early_sync_err", 32'(bus.sync_err), 32'd1);
        chk("early_y0", 32'(bus.y0), 32'h03);
        step("early_04", 1, 0, 8'h04, 4'hF);
        step("early_05", 1, 0, 8'h05, 4'hF);
        step("early_06", 1, 0, 8'h06, 4'hF);

        // Missing sync at slot 0.
        step("missing_55", 1, 0, 8'h55, 4'hF);
        chk("missing_unlocked", 32'(bus.locked), 32'd0);

        // Masked channels with idle gaps between beats.
        for (int i = 0; i < 4; i++) begin
            step("mask_beat", 1, (i == 0), 8'hC0 + 8'(i), 4'b0101);
            step("mask_gap", 0, 1, 8'hEE, 4'b0101);
            step("mask_gap", 0, 0, 8'hEF, 4'b0101);
        end

        // Random traffic, sync mostly on frame boundaries.
        for (int n = 0; n < 400; n++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            s = (m_pos == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
            step("rand", v, s, 8'($urandom), 4'($urandom));
        end

        // 256 frames bring frame_cnt back to its starting value.
        c0 = m_cnt;
        for (int f = 0; f < 256; f++) frame("wrap", 8'(f), 4'hF);
        chk("wrap_cnt", 32'(bus.frame_cnt), 32'(c0));

        // Asynchronous reset mid-frame, then relock.
        step("pre_rst_a", 1, 1, 8'h71, 4'hF);
        step("pre_rst_b", 1, 0, 8'h72, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst_n = 1'b1;
        step("post_rst_nosync", 1, 0, 8'h73, 4'hF);
        chk("post_rst_unlocked", 32'(bus.locked), 32'd0);
        step("relock", 1, 1, 8'h81, 4'hF);
        chk("relock_locked", 32'(bus.locked), 32'd1);
        step("relock_b", 1, 0, 8'h82, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
